// File: rtl/hdr_to_stream_var_if.sv
// Handshake bundle for the variable-length header inserter: header port, input stream
// and realigned output stream. The slave modport is the inserter's view.
interface hdr_to_stream_var_if #(
  parameter int DATA_W     = 512,
  parameter int HDR_MAX_W  = 480,
  parameter int PADBYTES_W = $clog2(DATA_W/8)
);
  logic                  hdr_val;
  logic [HDR_MAX_W-1:0]  hdr;
  logic [7:0]            hdr_bytes;
  logic                  hdr_has_data;
  logic                  hdr_rdy;

  logic                  in_val;
  logic [DATA_W-1:0]     in_data;
  logic                  in_last;
  logic [PADBYTES_W-1:0] in_padbytes;
  logic                  in_rdy;

  logic                  out_val;
  logic [DATA_W-1:0]     out_data;
  logic                  out_last;
  logic [PADBYTES_W-1:0] out_padbytes;
  logic                  out_rdy;

  modport slave (
    input  hdr_val, hdr, hdr_bytes, hdr_has_data,
    output hdr_rdy,
    input  in_val, in_data, in_last, in_padbytes,
    output in_rdy,
    output out_val, out_data, out_last, out_padbytes,
    input  out_rdy
  );

  modport master (
    output hdr_val, hdr, hdr_bytes, hdr_has_data,
    input  hdr_rdy,
    output in_val, in_data, in_last, in_padbytes,
    input  in_rdy,
    input  out_val, out_data, out_last, out_padbytes,
    output out_rdy
  );
endinterface

// File: rtl/hdr_to_stream_var.sv
// Prepends a per-packet header of 0..HDR_MAX_W/8 bytes to an MSB-first byte stream,
// realigning data lines with a byte-granular shifter and flushing any spill-over line.
module hdr_to_stream_var #(
  parameter int DATA_W     = 512,
  parameter int HDR_MAX_W  = 480,
  parameter int PADBYTES_W = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                rst,
  hdr_to_stream_var_if.slave  bus
);
  localparam int D  = DATA_W / 8;
  localparam int PW = PADBYTES_W;
  localparam int SW = PW + 4;

  // state  | meaning
  // IDLE   | waiting for a header; only state that accepts one
  // STREAM | merging saved header/carry bytes with each input line
  // FLUSH  | emitting the final line holding only carried bytes
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] save_q, save_d;
  logic [PW-1:0]     s_q, s_d;
  logic [PW-1:0]     pad_q, pad_d;

  logic [PW-1:0]     hdr_s;
  logic [PW:0]       tail_bytes;
  logic [SW-1:0]     head_sh, tail_sh;
  logic [DATA_W-1:0] head_mask, merged, carry;
  logic [PW-1:0]     pad_diff;
  logic              line_acc, ends_here;

  assign hdr_s      = PW'(bus.hdr_bytes);
  assign head_sh    = SW'({s_q, 3'b000});
  assign tail_bytes = (PW+1)'(D) - {1'b0, s_q};
  assign tail_sh    = {tail_bytes, 3'b000};

  // head_mask covers the top S bytes; S=0 shifts the carry fully out.
  assign head_mask  = ~({DATA_W{1'b1}} >> head_sh);
  assign merged     = (save_q & head_mask) | ((bus.in_data >> head_sh) & ~head_mask);
  assign carry      = bus.in_data << tail_sh;

  // Same mod-D difference serves the in-line last padbytes and the flush padbytes.
  assign pad_diff   = bus.in_padbytes - s_q;
  assign line_acc   = bus.in_val & bus.out_rdy;
  assign ends_here  = bus.in_last & (bus.in_padbytes >= s_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      save_q  <= '0;
      s_q     <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      save_q  <= save_d;
      s_q     <= s_d;
      pad_q   <= pad_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    save_d           = save_q;
    s_d              = s_q;
    pad_d            = pad_q;
    bus.hdr_rdy      = 1'b0;
    bus.in_rdy       = 1'b0;
    bus.out_val      = 1'b0;
    bus.out_data     = '0;
    bus.out_last     = 1'b0;
    bus.out_padbytes = '0;

    unique case (state_q)
      IDLE: begin
        bus.hdr_rdy = 1'b1;
        if (bus.hdr_val) begin
          if (bus.hdr_has_data || (hdr_s != '0)) begin
            save_d = {bus.hdr, {(DATA_W-HDR_MAX_W){1'b0}}};
            s_d    = hdr_s;
          end
          if (bus.hdr_has_data) begin
            state_d = STREAM;
          end else if (hdr_s != '0) begin
            pad_d   = '0 - hdr_s;
            state_d = FLUSH;
          end
        end
      end

      STREAM: begin
        bus.in_rdy   = bus.out_rdy;
        bus.out_val  = bus.in_val;
        bus.out_data = merged;
        if (bus.in_val && ends_here) begin
          bus.out_last     = 1'b1;
          bus.out_padbytes = pad_diff;
        end
        if (line_acc) begin
          save_d = (carry & head_mask) | (save_q & ~head_mask);
          if (bus.in_last) begin
            if (ends_here) begin
              state_d = IDLE;
            end else begin
              pad_d   = pad_diff;
              state_d = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        bus.out_val      = 1'b1;
        bus.out_last     = 1'b1;
        bus.out_data     = save_q & head_mask;
        bus.out_padbytes = pad_q;
        if (bus.out_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hdr_to_stream_var.sv
// Randomized directed bench for hdr_to_stream_var: each packet's expected output is the
// header bytes followed by the data bytes, cut into D-byte lines.
module tb_hdr_to_stream_var;
  localparam int DATA_W    = 512;
  localparam int HDR_MAX_W = 480;
  localparam int D         = DATA_W / 8;
  localparam int HB        = HDR_MAX_W / 8;
  localparam int PW        = $clog2(D);
  localparam int LIMIT     = 3000;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hdr_to_stream_var_if #(.DATA_W(DATA_W), .HDR_MAX_W(HDR_MAX_W), .PADBYTES_W(PW)) bus ();

  hdr_to_stream_var #(.DATA_W(DATA_W), .HDR_MAX_W(HDR_MAX_W), .PADBYTES_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_pkt(input int s, input bit has_data, input int n, input int stall_pct,
                         input int rst_after);
    byte unsigned      hq[$];
    byte unsigned      dq[$];
    byte unsigned      eq[$];
    byte unsigned      b;
    logic [HDR_MAX_W-1:0] hv;
    logic [DATA_W-1:0] line, mask;
    int n_in, n_out, in_pad, exp_pad, in_idx, out_idx, cyc, vb;

    hv = '0;
    for (int i = 0; i < HB; i++) begin
      b = 8'($urandom);
      if (i < s) hq.push_back(b);
      hv[HDR_MAX_W-1-8*i -: 8] = b;
    end
    if (has_data) for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
    foreach (hq[i]) eq.push_back(hq[i]);
    foreach (dq[i]) eq.push_back(dq[i]);

    n_out   = (eq.size() + D - 1) / D;
    exp_pad = (D - (eq.size() % D)) % D;
    n_in    = has_data ? (n + D - 1) / D : 0;
    in_pad  = (D - (n % D)) % D;

    @(negedge clk);
    bus.in_val       = 1'b0;
    bus.out_rdy      = 1'b1;
    bus.hdr_val      = 1'b1;
    bus.hdr          = hv;
    bus.hdr_bytes    = 8'(s);
    bus.hdr_has_data = has_data;
    #1;
    chk("hdr_rdy_idle", DATA_W'(bus.hdr_rdy), DATA_W'(1));
    @(negedge clk);
    bus.hdr_val = 1'b0;
    bus.hdr     = HDR_MAX_W'({$urandom, $urandom});

    in_idx  = 0;
    out_idx = 0;
    cyc     = 0;
    while ((in_idx < n_in || out_idx < n_out) && cyc < LIMIT) begin
      bus.out_rdy = ($urandom_range(99) >= stall_pct);
      bus.in_val  = (in_idx < n_in) && ($urandom_range(99) >= stall_pct / 2);
      line = DATA_W'({$urandom, $urandom});
      for (int k = 0; k < D; k++)
        if (in_idx * D + k < n) line[DATA_W-1-8*k -: 8] = dq[in_idx * D + k];
      bus.in_data     = line;
      bus.in_last     = (in_idx == n_in - 1);
      bus.in_padbytes = (in_idx == n_in - 1) ? PW'(in_pad) : '0;
      #1;
      if (bus.in_val) chk("in_rdy_tracks_out_rdy", DATA_W'(bus.in_rdy), DATA_W'(bus.out_rdy));
      if (bus.out_val && bus.out_rdy) begin
        if (out_idx >= n_out) begin
          chk("extra_out_line", DATA_W'(out_idx), DATA_W'(n_out - 1));
        end else begin
          vb   = (out_idx == n_out - 1) ? D - exp_pad : D;
          line = '0;
          mask = '0;
          for (int k = 0; k < vb; k++) begin
            line[DATA_W-1-8*k -: 8] = eq[out_idx * D + k];
            mask[DATA_W-1-8*k -: 8] = 8'hFF;
          end
          chk("out_data", bus.out_data & mask, line);
          chk("out_last", DATA_W'(bus.out_last), DATA_W'(out_idx == n_out - 1));
          chk("out_padbytes", DATA_W'(bus.out_padbytes),
              DATA_W'((out_idx == n_out - 1) ? exp_pad : 0));
        end
        out_idx++;
      end
      if (bus.in_val && bus.in_rdy) in_idx++;
      if (rst_after > 0 && in_idx == rst_after) begin
        rst = 1'b1;
        #1;
        chk("rst_out_val", DATA_W'(bus.out_val), '0);
        chk("rst_in_rdy", DATA_W'(bus.in_rdy), '0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_hdr_rdy", DATA_W'(bus.hdr_rdy), DATA_W'(1));
        bus.in_val = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    chk("pkt_out_lines", DATA_W'(out_idx), DATA_W'(n_out));
    chk("pkt_in_lines", DATA_W'(in_idx), DATA_W'(n_in));
    bus.in_val  = 1'b0;
    bus.out_rdy = 1'b1;
    #1;
    chk("idle_out_val", DATA_W'(bus.out_val), '0);
    chk("idle_hdr_rdy", DATA_W'(bus.hdr_rdy), DATA_W'(1));
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    bus.hdr_val      = 1'b0;
    bus.hdr          = '0;
    bus.hdr_bytes    = '0;
    bus.hdr_has_data = 1'b0;
    bus.in_val       = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.in_padbytes  = '0;
    bus.out_rdy      = 1'b0;
    #1;
    chk("reset_hdr_rdy", DATA_W'(bus.hdr_rdy), DATA_W'(1));
    chk("reset_out_val", DATA_W'(bus.out_val), '0);
    chk("reset_in_rdy", DATA_W'(bus.in_rdy), '0);
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_out_last", DATA_W'(bus.out_last), '0);
    chk("reset_out_padbytes", DATA_W'(bus.out_padbytes), '0);
    @(negedge clk);
    rst = 1'b0;

    run_pkt(20, 1'b1, 14, 0, 0);    // one line, padbytes 30
    run_pkt(20, 1'b1, 118, 0, 0);   // spill into flush line, padbytes 54
    run_pkt(0, 1'b1, 187, 0, 0);    // bypass, padbytes 5
    run_pkt(40, 1'b0, 0, 0, 0);     // header-only flush, padbytes 24
    run_pkt(0, 1'b0, 0, 0, 0);      // dropped header, no output
    run_pkt(20, 1'b1, 118, 40, 0);  // stalls on both sides
    run_pkt(20, 1'b1, 44, 0, 0);    // in_padbytes == S exactly
    run_pkt(20, 1'b1, 45, 0, 0);    // in_padbytes == S-1, flush padbytes 63
    run_pkt(HB, 1'b1, 64, 20, 0);   // maximum header
    run_pkt(HB, 1'b0, 0, 20, 0);
    run_pkt(20, 1'b1, 192, 0, 1);   // reset mid-stream
    run_pkt(20, 1'b1, 118, 0, 0);
    for (int r = 0; r < 25; r++)
      run_pkt($urandom_range(HB), 1'b1, $urandom_range(300, 1), 30, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
